// File: rtl/dp_sram_be_if.sv
// dp_sram_be_if: the signal bundle for one port of dp_sram_be.
//   master drives: req, we, be, addr, wdata
//   slave drives : rvalid (one-cycle read-result pulse), rdata (held between pulses)
interface dp_sram_be_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18
);
  localparam int NB = DATA_WIDTH / 8;

  logic                  req;
  logic                  we;
  logic [NB-1:0]         be;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output req, we, be, addr, wdata,
    input  rvalid, rdata
  );

  modport slave (
    input  req, we, be, addr, wdata,
    output rvalid, rdata
  );
endinterface

// File: rtl/dp_sram_be.sv
// dp_sram_be: true dual-port word-addressed SRAM with per-byte write enables.
//
// Features:
//   - little-endian byte lanes
//   - a req/rvalid read handshake
//   - an optional output register
//   - read-first behaviour across ports
//   - byte-merged dual writes
//   - a post-reset clear sweep
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        synchronous active-high reset
//   init_done  1 once the clear sweep is finished; requests are accepted only then
//   a, b       dp_sram_be_if.slave ports: req/we/be/addr/wdata in, rvalid/rdata out
//   coll_cnt   (only with DP_SRAM_COLLISION_CNT_EN) saturating count of cycles in
//              which both ports wrote the same word with overlapping byte enables
//
// Parameters:
//   DATA_WIDTH      word width (multiple of 8)
//   ADDR_WIDTH      word address width; DEPTH = 2**ADDR_WIDTH
//   OUT_REG         0: read latency 1; 1: read latency 2
//   CLEAR_ON_RESET  1: zero the array after every reset; 0: retain contents
//
// Optional feature macro: DP_SRAM_COLLISION_CNT_EN
module dp_sram_be #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 18,
  parameter int OUT_REG        = 0,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic        clk,
  input  logic        rst,
  output logic        init_done,
`ifdef DP_SRAM_COLLISION_CNT_EN
  output logic [15:0] coll_cnt,
`endif
  dp_sram_be_if.slave a,
  dp_sram_be_if.slave b
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] ptr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Index 0 is port A, index 1 is port B.
  logic [1:0][NB-1:0]         be_v;
  logic [1:0][ADDR_WIDTH-1:0] addr_v;
  logic [1:0][DATA_WIDTH-1:0] wdata_v;

  assign be_v    = {b.be, a.be};
  assign addr_v  = {b.addr, a.addr};
  assign wdata_v = {b.wdata, a.wdata};

  logic       accept;
  logic [1:0] wr_acc;
  logic [1:0] rd_acc;
  logic       same_addr;
  logic       init_wr;

  // Requests are dropped while sweeping or while rst is asserted.
  assign accept    = init_done & ~rst;
  assign wr_acc    = {accept & b.req &  b.we, accept & a.req &  a.we};
  assign rd_acc    = {accept & b.req & ~b.we, accept & a.req & ~a.we};
  assign same_addr = (a.addr == b.addr);
  assign init_wr   = (state == ST_INIT) & ~rst;

  // On a same-word dual write, port A owns every lane it enables.
  // Port B only lands on the lanes that A leaves alone.
  function automatic logic [1:0][NB-1:0] merge_lanes(
    input logic [1:0]         wr,
    input logic [1:0][NB-1:0] be,
    input logic               same
  );
    logic [1:0][NB-1:0] en;
    en[0] = {NB{wr[0]}} & be[0];
    en[1] = {NB{wr[1]}} & be[1];
    if (same) en[1] = en[1] & ~en[0];
    return en;
  endfunction

  logic [1:0][NB-1:0] lane_we;
  assign lane_we = merge_lanes(wr_acc, be_v, same_addr);

  // Control FSM: INIT sweeps one word per cycle, RUN serves the ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
      ptr       <= '0;
      init_done <= 1'b0;
    end else begin
      case (state)
        ST_INIT: begin
          ptr <= ptr + 1'b1;
          if (ptr == '1) begin
            state     <= ST_RUN;
            init_done <= 1'b1;
          end
        end
        ST_RUN:  init_done <= 1'b1;
        default: state <= ST_RUN;
      endcase
    end
  end

  // Array write: sweep clears, then byte-lane writes from both ports.
  always_ff @(posedge clk) begin
    if (init_wr) mem[ptr] <= '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < NB; i++) begin
        if (lane_we[p][i]) mem[addr_v[p]][8*i +: 8] <= wdata_v[p][8*i +: 8];
      end
    end
  end

  // Stage p0: array read.
  // The non-blocking update means the read sees the pre-write word (read-first).
  logic [1:0]                 vld_p0;
  logic [1:0][DATA_WIDTH-1:0] rd_p0;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0 <= '0;
      rd_p0  <= '0;
    end else begin
      vld_p0 <= rd_acc;
      for (int p = 0; p < 2; p++) begin
        if (rd_acc[p]) rd_p0[p] <= mem[addr_v[p]];
      end
    end
  end

  logic [1:0]                 vld_out;
  logic [1:0][DATA_WIDTH-1:0] rd_out;

  if (OUT_REG != 0) begin : g_out_reg
    logic [1:0]                 vld_p1;
    logic [1:0][DATA_WIDTH-1:0] rd_p1;

    // Stage p1: optional output register; data only moves with a valid.
    always_ff @(posedge clk) begin
      if (rst) begin
        vld_p1 <= '0;
        rd_p1  <= '0;
      end else begin
        vld_p1 <= vld_p0;
        for (int p = 0; p < 2; p++) begin
          if (vld_p0[p]) rd_p1[p] <= rd_p0[p];
        end
      end
    end

    assign vld_out = vld_p1;
    assign rd_out  = rd_p1;
  end else begin : g_no_out_reg
    assign vld_out = vld_p0;
    assign rd_out  = rd_p0;
  end

  assign a.rvalid = vld_out[0];
  assign a.rdata  = rd_out[0];
  assign b.rvalid = vld_out[1];
  assign b.rdata  = rd_out[1];

`ifdef DP_SRAM_COLLISION_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      coll_cnt <= '0;
    end else if (wr_acc == 2'b11 && same_addr && (|(a.be & b.be)) &&
                 coll_cnt != 16'hFFFF) begin
      coll_cnt <= coll_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dp_sram_be.sv
// tb_dp_sram_be: scoreboard bench for dp_sram_be.
//   u0: 16-word array, CLEAR_ON_RESET=1, OUT_REG=0
//   u1: 16-word array, CLEAR_ON_RESET=0, OUT_REG=1
// Expected read data and the cycle it is due are queued at issue time;
// a negedge monitor pops and compares every rvalid pulse.
module tb_dp_sram_be;
  localparam int DW = 32;
  localparam int AW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0, rst1, init0, init1;
  int   cyc = 0;
  int   checks = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  dp_sram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a0 ();
  dp_sram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b0 ();
  dp_sram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) a1 ();
  dp_sram_be_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) b1 ();

`ifdef DP_SRAM_COLLISION_CNT_EN
  logic [15:0] coll0, coll1;
`endif

  dp_sram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(0), .CLEAR_ON_RESET(1)) u0 (
    .clk       (clk),
    .rst       (rst0),
    .init_done (init0),
`ifdef DP_SRAM_COLLISION_CNT_EN
    .coll_cnt  (coll0),
`endif
    .a         (a0),
    .b         (b0)
  );

  dp_sram_be #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .OUT_REG(1), .CLEAR_ON_RESET(0)) u1 (
    .clk       (clk),
    .rst       (rst1),
    .init_done (init1),
`ifdef DP_SRAM_COLLISION_CNT_EN
    .coll_cnt  (coll1),
`endif
    .a         (a1),
    .b         (b1)
  );

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  exp_t q_a0[$];
  exp_t q_b0[$];
  exp_t q_a1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cmp_rd(input string name, input logic have, input exp_t e, input logic [31:0] d);
    if (!have) begin
      checks++;
      fails++;
      $display("FAIL %s unexpected rvalid: got data %h at cycle %0d, expected no pulse", name, d, cyc);
    end else begin
      chk({name, " rdata"}, d, e.data);
      chk({name, " rvalid cycle"}, cyc, e.due);
    end
  endtask

  // Monitor: compares every read-result pulse against the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    logic h;
    if (a0.rvalid === 1'b1) begin
      h = (q_a0.size() > 0);
      e = h ? q_a0.pop_front() : '{32'h0, 0};
      cmp_rd("u0.a", h, e, a0.rdata);
    end
    if (b0.rvalid === 1'b1) begin
      h = (q_b0.size() > 0);
      e = h ? q_b0.pop_front() : '{32'h0, 0};
      cmp_rd("u0.b", h, e, b0.rdata);
    end
    if (a1.rvalid === 1'b1) begin
      h = (q_a1.size() > 0);
      e = h ? q_a1.pop_front() : '{32'h0, 0};
      cmp_rd("u1.a", h, e, a1.rdata);
    end
    if (b1.rvalid === 1'b1) begin
      cmp_rd("u1.b", 1'b0, '{32'h0, 0}, b1.rdata);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    a0.req = 1'b0;
    b0.req = 1'b0;
    a1.req = 1'b0;
    b1.req = 1'b0;
  endtask

  task automatic wr0(input bit port, input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    if (port == 1'b0) begin
      a0.req = 1'b1; a0.we = 1'b1; a0.addr = addr; a0.wdata = d; a0.be = be;
    end else begin
      b0.req = 1'b1; b0.we = 1'b1; b0.addr = addr; b0.wdata = d; b0.be = be;
    end
  endtask

  // Read on u0 (latency 1). chk_it=0 issues a read that must not produce a pulse.
  task automatic rd0(input bit port, input logic [3:0] addr, input logic [31:0] exp, input bit chk_it);
    if (port == 1'b0) begin
      a0.req = 1'b1; a0.we = 1'b0; a0.addr = addr; a0.be = 4'h0;
      if (chk_it) q_a0.push_back('{exp, cyc + 1});
    end else begin
      b0.req = 1'b1; b0.we = 1'b0; b0.addr = addr; b0.be = 4'h0;
      if (chk_it) q_b0.push_back('{exp, cyc + 1});
    end
  endtask

  task automatic wr1(input logic [3:0] addr, input logic [31:0] d, input logic [3:0] be);
    a1.req = 1'b1; a1.we = 1'b1; a1.addr = addr; a1.wdata = d; a1.be = be;
  endtask

  // Read on u1 (latency 2).
  task automatic rd1(input logic [3:0] addr, input logic [31:0] exp, input bit chk_it);
    a1.req = 1'b1; a1.we = 1'b0; a1.addr = addr; a1.be = 4'h0;
    if (chk_it) q_a1.push_back('{exp, cyc + 2});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q_a0.size() + q_b0.size() + q_a1.size()) != 0 && n < 12) begin
      step();
      n++;
    end
    if ((q_a0.size() + q_b0.size() + q_a1.size()) != 0) begin
      checks++;
      fails++;
      $display("FAIL drain: %0d reads still pending, expected 0", q_a0.size() + q_b0.size() + q_a1.size());
      q_a0.delete();
      q_b0.delete();
      q_a1.delete();
    end
  endtask

  function automatic logic [31:0] pat(input int i);
    return 32'h8000_0000 | (32'h0101_0101 * 32'(i));
  endfunction

  int n;

  initial begin
    a0.req = 0; a0.we = 0; a0.be = 0; a0.addr = 0; a0.wdata = 0;
    b0.req = 0; b0.we = 0; b0.be = 0; b0.addr = 0; b0.wdata = 0;
    a1.req = 0; a1.we = 0; a1.be = 0; a1.addr = 0; a1.wdata = 0;
    b1.req = 0; b1.we = 0; b1.be = 0; b1.addr = 0; b1.wdata = 0;
    rst0 = 1'b1;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    chk("u0 reset init_done", {31'b0, init0}, 32'd0);
    chk("u0 reset a rvalid", {31'b0, a0.rvalid}, 32'd0);
    chk("u0 reset a rdata", a0.rdata, 32'h0);
    chk("u0 reset b rdata", b0.rdata, 32'h0);
`ifdef DP_SRAM_COLLISION_CNT_EN
    chk("u0 reset coll_cnt", {16'b0, coll0}, 32'd0);
`endif

    // Test 1: sweep length.
    // A write and a read are issued at sweep cycle 8 and must be dropped.
    rst0 = 1'b0;
    n = 0;
    while (!init0 && n < 40) begin
      if (n == 8) begin
        wr0(0, 4'd1, 32'h1234_5678, 4'hF);
        rd0(1, 4'd1, 32'h0, 1'b0);
      end
      step();
      n++;
    end
    chk("u0 init_done low cycles", 32'(n), 32'd16);
    for (int i = 0; i < 16; i++) begin
      rd0(0, 4'(i), 32'h0, 1'b1);
      step();
    end
    drain();

    // Test 2: partial-lane overwrite from the other port
    wr0(0, 4'd3, 32'hDEAD_BEEF, 4'b1111);
    step();
    wr0(1, 4'd3, 32'h0000_1122, 4'b0011);
    step();
    rd0(0, 4'd3, 32'hDEAD_1122, 1'b1);
    step();
    drain();

    // Test 3: same-word dual write.
    // Byte lanes, low to high: lane0 A (AA), lane1 old (11),
    // lane2 overlap so A wins (AA), lane3 B (BB).
    wr0(0, 4'd5, 32'h1111_1111, 4'hF);
    step();
    wr0(0, 4'd5, 32'hAAAA_AAAA, 4'b0101);
    wr0(1, 4'd5, 32'hBBBB_BBBB, 4'b1100);
    step();
`ifdef DP_SRAM_COLLISION_CNT_EN
    chk("u0 coll_cnt after overlap", {16'b0, coll0}, 32'd1);
`endif
    rd0(0, 4'd5, 32'hBBAA_11AA, 1'b1);
    step();
    drain();

    // Test 4: cross-port read-first, then read-after-write
    wr0(0, 4'd7, 32'h0102_0304, 4'hF);
    step();
    wr0(0, 4'd7, 32'hFFFF_FFFF, 4'hF);
    rd0(1, 4'd7, 32'h0102_0304, 1'b1);
    step();
    rd0(1, 4'd7, 32'hFFFF_FFFF, 1'b1);
    step();
    drain();

    // Test 5: fill via both ports at different words, then a be=0 no-op,
    // then streamed reads on both ports every cycle.
    for (int i = 0; i < 8; i++) begin
      wr0(0, 4'(i), pat(i), 4'hF);
      wr0(1, 4'(i + 8), pat(i + 8), 4'hF);
      step();
    end
    wr0(0, 4'd0, 32'hFFFF_FFFF, 4'h0);
    step();
    for (int i = 0; i < 16; i++) begin
      rd0(0, 4'(i), pat(i), 1'b1);
      rd0(1, 4'(15 - i), pat(15 - i), 1'b1);
      step();
    end
    drain();
`ifdef DP_SRAM_COLLISION_CNT_EN
    chk("u0 coll_cnt no new overlap", {16'b0, coll0}, 32'd1);
`endif

    // Test 6: reset mid-sweep restarts the full sweep
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    repeat (8) step();
    rst0 = 1'b1;
    step();
    rst0 = 1'b0;
    n = 0;
    while (!init0 && n < 40) begin
      step();
      n++;
    end
    chk("u0 init_done low after restart", 32'(n), 32'd16);
`ifdef DP_SRAM_COLLISION_CNT_EN
    chk("u0 coll_cnt cleared", {16'b0, coll0}, 32'd0);
`endif
    rd0(0, 4'd3, 32'h0, 1'b1);
    rd0(1, 4'd9, 32'h0, 1'b1);
    step();
    drain();

    // u1: no sweep, output register, contents retained across reset
    chk("u1 reset init_done", {31'b0, init1}, 32'd0);
    chk("u1 reset rdata", a1.rdata, 32'h0);
    rst1 = 1'b0;
    step();
    chk("u1 init_done after one cycle", {31'b0, init1}, 32'd1);
    wr1(4'd2, 32'hCAFE_F00D, 4'hF);
    step();
    rd1(4'd2, 32'hCAFE_F00D, 1'b1);
    step();
    drain();

    // In-flight read killed by reset: no pulse may follow
    rd1(4'd2, 32'h0, 1'b0);
    step();
    rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    chk("u1 rdata cleared by reset", a1.rdata, 32'h0);
    step();
    rd1(4'd2, 32'hCAFE_F00D, 1'b1);
    step();
    drain();
    repeat (3) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
